// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list lowest-first and
// issues register/address pairs, then reports the base writeback value.
// Optional build macro LDM_EMPTY_LIST_R15_EN: an empty list transfers r15 with N=16.
module ldm_stm_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           reg_list,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  up,
  input  logic                  pre,
  output logic                  busy,
  output logic                  xfer_valid,
  input  logic                  xfer_ready,
  output logic [3:0]            reg_num,
  output logic [ADDR_WIDTH-1:0] xfer_addr,
  output logic [4:0]            xfer_count,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  done
);

  localparam int unsigned LIST_W = 16;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam logic [ADDR_WIDTH-1:0] WORD = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [LIST_W-1:0]       r_mask;
  logic [CNT_W-1:0]        r_n;
  logic [CNT_W-1:0]        r_count;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic                    r_up;
  logic                    r_pre;
  logic                    r_busy;
  logic                    r_valid;
  logic [REG_W-1:0]        r_reg_num;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_wb;
  logic                    r_done;

  logic [LIST_W-1:0]       w_rest;
  logic [LIST_W-1:0]       w_enc_in;
  logic [REG_W-1:0]        w_enc;
  logic [CNT_W-1:0]        w_list_n;
  logic [LIST_W-1:0]       w_cap_mask;
  logic [CNT_W-1:0]        w_cap_n;
  logic [ADDR_WIDTH-1:0]   w_span;
  logic [ADDR_WIDTH-1:0]   w_start_addr;
  logic [ADDR_WIDTH-1:0]   w_wb;

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(LIST_W); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Priority encoder: index of the lowest set bit (0 when empty).
  function automatic logic [REG_W-1:0] lowest_bit(input logic [LIST_W-1:0] v);
    logic [REG_W-1:0] idx;
    idx = '0;
    for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
      if (v[i]) idx = REG_W'(i);
    end
    return idx;
  endfunction

  // The single encoder serves SETUP (first bit) and XFER (bit after the current one).
  always_comb begin
    w_rest   = r_mask & (r_mask - LIST_W'(1));
    w_enc_in = (r_state == S_SETUP) ? r_mask : w_rest;
    w_enc    = lowest_bit(w_enc_in);
    w_list_n = popcount(reg_list);
  end

`ifdef LDM_EMPTY_LIST_R15_EN
  always_comb begin
    w_cap_mask = (reg_list == '0) ? LIST_W'(16'h8000) : reg_list;
    w_cap_n    = (reg_list == '0) ? CNT_W'(16) : w_list_n;
  end
`else
  always_comb begin
    w_cap_mask = reg_list;
    w_cap_n    = w_list_n;
  end
`endif

  // Address range always ascends; decrement modes start below the base.
  always_comb begin
    w_span = ADDR_WIDTH'({r_n, 2'b00});
    unique case ({r_up, r_pre})
      2'b10:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + WORD;
      2'b00:   w_start_addr = r_base - w_span + WORD;
      default: w_start_addr = r_base - w_span;
    endcase
    w_wb = r_up ? (r_base + w_span) : (r_base - w_span);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_n       <= '0;
      r_count   <= '0;
      r_base    <= '0;
      r_up      <= 1'b0;
      r_pre     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_reg_num <= '0;
      r_addr    <= '0;
      r_wb      <= '0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask  <= w_cap_mask;
            r_n     <= w_cap_n;
            r_count <= w_list_n;
            r_base  <= base_addr;
            r_up    <= up;
            r_pre   <= pre;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_wb <= w_wb;
          if (r_mask != '0) begin
            r_valid   <= 1'b1;
            r_reg_num <= w_enc;
            r_addr    <= w_start_addr;
            r_state   <= S_XFER;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_XFER: begin
          if (xfer_ready) begin
            r_mask <= w_rest;
            if (w_rest == '0) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_reg_num <= w_enc;
              r_addr    <= r_addr + WORD;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign xfer_valid = r_valid;
  assign reg_num    = r_reg_num;
  assign xfer_addr  = r_addr;
  assign xfer_count = r_count;
  assign wb_addr    = r_wb;
  assign done       = r_done;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: table of no-stall instructions plus
// hand-written stall, reset-abort and ignored-start sequences.
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        up;
  logic        pre;
  logic        busy;
  logic        xfer_valid;
  logic        xfer_ready;
  logic [3:0]  reg_num;
  logic [31:0] xfer_addr;
  logic [4:0]  xfer_count;
  logic [31:0] wb_addr;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  ldm_stm_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .up         (up),
    .pre        (pre),
    .busy       (busy),
    .xfer_valid (xfer_valid),
    .xfer_ready (xfer_ready),
    .reg_num    (reg_num),
    .xfer_addr  (xfer_addr),
    .xfer_count (xfer_count),
    .wb_addr    (wb_addr),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] reg_list;
    logic [31:0] base;
    logic        up;
    logic        pre;
    int          exp_n;
    logic [4:0]  exp_count;
    logic [31:0] exp_first;
    logic [31:0] exp_wb;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  task automatic issue(input logic [15:0] l, input logic [31:0] b, input logic u, input logic p);
    @(negedge clk);
    start = 1'b1; reg_list = l; base_addr = b; up = u; pre = p;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] mask;
    logic [3:0]  er;
    int cyc;
    int nx;
    bit seen_done;
    mask = v.reg_list;
`ifdef LDM_EMPTY_LIST_R15_EN
    if (mask == 16'h0) mask = 16'h8000;
`endif
    xfer_ready = 1'b1;
    issue(v.reg_list, v.base, v.up, v.pre);
    cyc = 0; nx = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("setup_busy", 32'(busy), 32'd1);
        check("setup_valid", 32'(xfer_valid), 32'd0);
        check("xfer_count", 32'(xfer_count), 32'(v.exp_count));
      end
      if (xfer_valid) begin
        er = lowest(mask);
        check("reg_num", 32'(reg_num), 32'(er));
        check("xfer_addr", xfer_addr, v.exp_first + 32'(nx * 4));
        mask[er] = 1'b0;
        nx++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", 32'(cyc), 32'(v.exp_done));
        check("wb_addr", wb_addr, v.exp_wb);
        check("num_xfers", 32'(nx), 32'(v.exp_n));
        check("done_busy", 32'(busy), 32'd1);
      end
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h8011, 32'h0000_1000, 1'b1, 1'b0, 3,  5'd3,  32'h0000_1000, 32'h0000_100C, 5};
    vecs[1] = '{16'h4003, 32'h0000_2000, 1'b0, 1'b1, 3,  5'd3,  32'h0000_1FF4, 32'h0000_1FF4, 5};
    vecs[2] = '{16'hFFFF, 32'h0000_0020, 1'b0, 1'b0, 16, 5'd16, 32'hFFFF_FFE4, 32'hFFFF_FFE0, 18};
`ifdef LDM_EMPTY_LIST_R15_EN
    vecs[3] = '{16'h0000, 32'h0000_3000, 1'b1, 1'b0, 1,  5'd0,  32'h0000_3000, 32'h0000_3040, 3};
`else
    vecs[3] = '{16'h0000, 32'h0000_3000, 1'b1, 1'b0, 0,  5'd0,  32'h0000_0000, 32'h0000_3000, 2};
`endif
    vecs[4] = '{16'h0001, 32'hFFFF_FFFC, 1'b1, 1'b1, 1,  5'd1,  32'h0000_0000, 32'h0000_0000, 3};
    vecs[5] = '{16'h8000, 32'h0000_0010, 1'b0, 1'b0, 1,  5'd1,  32'h0000_0010, 32'h0000_000C, 3};

    reset = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0; up = 1'b0; pre = 1'b0;
    xfer_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(xfer_valid), 32'd0);
    check("rst_reg_num", 32'(reg_num), 32'd0);
    check("rst_addr", xfer_addr, 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_wb", wb_addr, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // IB with the first pair stalled for three cycles.
    xfer_ready = 1'b0;
    issue(16'h0006, 32'h0000_0100, 1'b1, 1'b1);
    @(negedge clk);
    check("stall_setup_count", 32'(xfer_count), 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(xfer_valid), 32'd1);
      check("stall_reg", 32'(reg_num), 32'd1);
      check("stall_addr", xfer_addr, 32'h0000_0104);
      if (k == 3) xfer_ready = 1'b1;
    end
    @(negedge clk);
    check("stall_reg2", 32'(reg_num), 32'd2);
    check("stall_addr2", xfer_addr, 32'h0000_0108);
    check("stall_nodone", 32'(done), 32'd0);
    @(negedge clk);
    check("stall_done", 32'(done), 32'd1);
    check("stall_wb", wb_addr, 32'h0000_0108);
    check("stall_valid_off", 32'(xfer_valid), 32'd0);
    @(negedge clk);

    // Reset during the second transfer aborts with no done.
    issue(16'h00F0, 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_reg1", 32'(reg_num), 32'd4);
    @(negedge clk);
    check("abort_reg2", 32'(reg_num), 32'd5);
    check("abort_addr2", xfer_addr, 32'h0000_0004);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(xfer_valid), 32'd0);
    check("abort_reg", 32'(reg_num), 32'd0);
    check("abort_addr", xfer_addr, 32'd0);
    check("abort_count", 32'(xfer_count), 32'd0);
    check("abort_wb", wb_addr, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    begin
      bit any_done;
      any_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done || xfer_valid) any_done = 1'b1;
      end
      check("abort_quiet", 32'(any_done), 32'd0);
    end

    // A start pulse during XFER must not disturb the in-flight list.
    xfer_ready = 1'b1;
    issue(16'h0003, 32'h0000_0400, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("ign_reg0", 32'(reg_num), 32'd0);
    check("ign_addr0", xfer_addr, 32'h0000_0400);
    start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h0; up = 1'b0; pre = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_reg1", 32'(reg_num), 32'd1);
    check("ign_addr1", xfer_addr, 32'h0000_0404);
    check("ign_count", 32'(xfer_count), 32'd2);
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    check("ign_wb", wb_addr, 32'h0000_0408);
    @(negedge clk);
    check("ign_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
